datamover_mm2s_responder: RTL
=============================

# datamover_mm2s_responder

Command-side responder for the datamover command/status protocol used by the stream masters in the accelerator library. Accepts 73-bit datamover commands on a slave command stream and reads the requested byte range from a local word-addressed memory read port. Emits the data as an AXI4-Stream, then returns one 8-bit status word per command. Serves as the MM2S end that the command-issuing stream master talks to, both in the accelerator fabric and as a bench-side model.

## Interface
- C_S_AXIS_CMD_DATA_WIDTH, 73, command word width
- C_M_AXIS_STS_DATA_WIDTH, 8, status word width
- C_M_AXIS_DATA_WIDTH, 32, data beat width (4 bytes)
- C_ADDR_WIDTH, 32, byte address width
- BTT_WIDTH, 23, bytes-to-transfer field width
- clk  in  1  single clock; all logic posedge
- rst  in  1  synchronous, active-high reset
- S_AXIS_CMD_TVALID / S_AXIS_CMD_TREADY  in/out  1  command handshake
- S_AXIS_CMD_TDATA  in  73  command: [22:0] BTT, [23] TYPE, [29:24] DSA, [30] EOF, [31] DRR, [63:32] SADDR, [67:64] TAG, [72:68] reserved
- M_AXIS_STS_TVALID / M_AXIS_STS_TREADY  out/in  1  status handshake
- M_AXIS_STS_TDATA  out  8  status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG
- M_AXIS_DATA_TVALID / M_AXIS_DATA_TREADY  out/in  1  data handshake
- M_AXIS_DATA_TDATA  out  32  data beat
- M_AXIS_DATA_TKEEP  out  4  byte enables
- M_AXIS_DATA_TLAST  out  1  last beat of an EOF command
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  32  word-aligned byte address
- mem_rd_data  in  32  valid the cycle after mem_rd_en; held until the next mem_rd_en

## Operation
- FSM states: IDLE, READ, DATA, STATUS.
- IDLE:
  - S_AXIS_CMD_TREADY=1.
  - On handshake, latch BTT, SADDR with bits [1:0] forced to 0, TAG, and EOF.
  - Load the beat counter with ceil(BTT/4), 21 bits. Load rem with BTT[1:0].
  - If BTT==0, go to STATUS; otherwise go to READ.
- READ: mem_rd_en=1, mem_rd_addr=cur_addr. Always go to DATA.
- DATA:
  - M_AXIS_DATA_TVALID=1, TDATA=mem_rd_data.
  - Final beat: TKEEP = rem==0 ? 4'hF : (1<<rem)-1. All other beats: TKEEP=4'hF.
  - TLAST = final beat && EOF.
  - On handshake: cur_addr += 4 and the counter decrements. If that was the final beat, go to STATUS; otherwise go to READ.
  - TDATA, TKEEP and TLAST are held stable while TREADY=0.
- STATUS:
  - M_AXIS_STS_TVALID=1, TDATA = {OKAY, 1'b0, 1'b0, INTERR, TAG}.
  - Normal completion gives OKAY=1, INTERR=0.
  - On handshake, go to IDLE.
- TYPE, DSA and DRR are ignored; every transfer is treated as INCR.
- Commands are processed strictly one at a time, in order.
- cur_addr wraps modulo 2^32.

## Timing
- Reset values: S_AXIS_CMD_TREADY=0, all TVALIDs=0, TLAST=0, TKEEP=0, mem_rd_en=0, mem_rd_addr=0, STS_TDATA=0, state=IDLE.
- S_AXIS_CMD_TREADY goes to 1 on the first cycle after rst deasserts.
- With the command handshake at cycle 0 and TREADY held high:
  - mem_rd_en at cycle 1.
  - Beat n (n from 0) valid at cycle 2+2n.
  - Status valid on the cycle after the last data handshake.
- Peak throughput: one beat per 2 cycles.
- The next command is accepted no earlier than the cycle after the status handshake.
- rst asserted mid-transfer aborts immediately: no status is issued and all outputs return to their reset values on the next edge.
- Simultaneous TVALID/TREADY deassertion rules follow AXI4-Stream: no valid is dropped before its handshake.

## Configuration
- DATAMOVER_RESP_ERR_CHECK_EN defined:
  - A command with BTT==0 or SADDR[1:0]!=0 goes directly from IDLE to STATUS.
  - No reads or beats are issued.
  - Status is OKAY=0, INTERR=1, e.g. 0x1T for tag T.
- Undefined:
  - BTT==0 returns OKAY status with no beats.
  - Misaligned SADDR is silently truncated to word alignment.
  - INTERR is constant 0.

## Structure
- Shared package datamover_pkg holds:
  - command field offsets and widths (BTT, TYPE, DSA, EOF, DRR, SADDR, TAG)
  - status bit positions
  - the FSM state typedef
  - the beat-width constant (4 bytes)
- No sub-module. KEEP generation and field decode are inline.

## Test plan
- Aligned transfer: BTT=16, SADDR=0x100, TAG=3, EOF=1, TREADY=1 → reads at 0x100/0x104/0x108/0x10C; 4 beats with TKEEP=F; TLAST on beat 4 only; status 0x83.
- Partial final beat: BTT=6, SADDR=0x200, TAG=5, EOF=0 → 2 beats with TKEEP F then 3; TLAST never asserted; status 0x85.
- Backpressure: BTT=8 with DATA_TREADY low for 5 cycles on beat 1, and STS_TREADY low 3 cycles → TDATA/TKEEP/STS_TDATA held stable; no extra mem_rd_en; exactly one status.
- Zero length: BTT=0, TAG=9 → macro undefined: status 0x89 at cycle 1, no beats; macro defined: status 0x19.
- Misaligned address: SADDR=0x102, BTT=4, TAG=1 → macro defined: status 0x11, no reads; undefined: read at 0x100, one beat, status 0x81.
- Reset mid-transfer: rst asserted during beat 2 of a BTT=32 command → next cycle all valids 0 and no status; a fresh command is then accepted and completes normally.

Source files
------------

// File: rtl/datamover_pkg.sv
// Shared definitions for the MM2S datamover responder: command/status field layout,
// FSM state type and small helpers for status word and final-beat byte enables.
package datamover_pkg;

    localparam int C_S_AXIS_CMD_DATA_WIDTH = 73;
    localparam int C_M_AXIS_STS_DATA_WIDTH = 8;
    localparam int C_M_AXIS_DATA_WIDTH     = 32;
    localparam int C_ADDR_WIDTH            = 32;
    localparam int BTT_WIDTH               = 23;

    localparam int BEAT_BYTES     = C_M_AXIS_DATA_WIDTH / 8;
    localparam int KEEP_WIDTH     = BEAT_BYTES;
    localparam int BEAT_CNT_WIDTH = BTT_WIDTH - 2;

    localparam int CMD_BTT_LSB    = 0;
    localparam int CMD_TYPE_BIT   = 23;
    localparam int CMD_DSA_LSB    = 24;
    localparam int CMD_DSA_WIDTH  = 6;
    localparam int CMD_EOF_BIT    = 30;
    localparam int CMD_DRR_BIT    = 31;
    localparam int CMD_SADDR_LSB  = 32;
    localparam int CMD_TAG_LSB    = 64;
    localparam int TAG_WIDTH      = 4;
    localparam int CMD_RSVD_LSB   = 68;
    localparam int CMD_RSVD_WIDTH = 5;

    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_TAG_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DATA,
        ST_STATUS
    } state_t;

    // Byte enables for the last beat: rem==0 means the beat is full.
    function automatic logic [KEEP_WIDTH-1:0] final_keep(input logic [1:0] rem);
        logic [KEEP_WIDTH:0] one_hot;
        one_hot = (KEEP_WIDTH+1)'(1) << rem;
        if (rem == 2'd0) begin
            return '1;
        end
        return KEEP_WIDTH'(one_hot - (KEEP_WIDTH+1)'(1));
    endfunction

    function automatic logic [C_M_AXIS_STS_DATA_WIDTH-1:0] sts_word(
        input logic                 okay,
        input logic                 interr,
        input logic [TAG_WIDTH-1:0] tag
    );
        logic [C_M_AXIS_STS_DATA_WIDTH-1:0] w;
        w = '0;
        w[STS_OKAY_BIT]   = okay;
        w[STS_SLVERR_BIT] = 1'b0;
        w[STS_DECERR_BIT] = 1'b0;
        w[STS_INTERR_BIT] = interr;
        w[STS_TAG_LSB +: TAG_WIDTH] = tag;
        return w;
    endfunction

endpackage

// File: rtl/datamover_mm2s_responder_if.sv
// Bundle of the command, status, data and memory-read buses of the MM2S responder.
// slave = responder side, master = command issuer / memory / stream sink side.
interface datamover_mm2s_responder_if;
    import datamover_pkg::*;

    logic                               S_AXIS_CMD_TVALID;
    logic                               S_AXIS_CMD_TREADY;
    logic [C_S_AXIS_CMD_DATA_WIDTH-1:0] S_AXIS_CMD_TDATA;

    logic                               M_AXIS_STS_TVALID;
    logic                               M_AXIS_STS_TREADY;
    logic [C_M_AXIS_STS_DATA_WIDTH-1:0] M_AXIS_STS_TDATA;

    logic                               M_AXIS_DATA_TVALID;
    logic                               M_AXIS_DATA_TREADY;
    logic [C_M_AXIS_DATA_WIDTH-1:0]     M_AXIS_DATA_TDATA;
    logic [KEEP_WIDTH-1:0]              M_AXIS_DATA_TKEEP;
    logic                               M_AXIS_DATA_TLAST;

    logic                               mem_rd_en;
    logic [C_ADDR_WIDTH-1:0]            mem_rd_addr;
    logic [C_M_AXIS_DATA_WIDTH-1:0]     mem_rd_data;

    modport slave (
        input  S_AXIS_CMD_TVALID, S_AXIS_CMD_TDATA,
        output S_AXIS_CMD_TREADY,
        output M_AXIS_STS_TVALID, M_AXIS_STS_TDATA,
        input  M_AXIS_STS_TREADY,
        output M_AXIS_DATA_TVALID, M_AXIS_DATA_TDATA, M_AXIS_DATA_TKEEP, M_AXIS_DATA_TLAST,
        input  M_AXIS_DATA_TREADY,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data
    );

    modport master (
        output S_AXIS_CMD_TVALID, S_AXIS_CMD_TDATA,
        input  S_AXIS_CMD_TREADY,
        input  M_AXIS_STS_TVALID, M_AXIS_STS_TDATA,
        output M_AXIS_STS_TREADY,
        input  M_AXIS_DATA_TVALID, M_AXIS_DATA_TDATA, M_AXIS_DATA_TKEEP, M_AXIS_DATA_TLAST,
        output M_AXIS_DATA_TREADY,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data
    );

endinterface

// File: rtl/datamover_mm2s_responder.sv
// MM2S datamover responder: one command at a time, read word -> emit beat, then one status.
// Optional DATAMOVER_RESP_ERR_CHECK_EN rejects zero-length or misaligned commands with INTERR.
module datamover_mm2s_responder
    import datamover_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    datamover_mm2s_responder_if.slave  bus
);

    state_t                    state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BEAT_CNT_WIDTH-1:0] beats_q, beats_d;
    logic [1:0]                rem_q, rem_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic                      eof_q, eof_d;

    logic [BTT_WIDTH-1:0]      cmd_btt;
    logic [C_ADDR_WIDTH-1:0]   cmd_saddr;
    logic [TAG_WIDTH-1:0]      cmd_tag;
    logic                      cmd_eof;
    logic [BTT_WIDTH:0]        btt_round;
    logic                      cmd_err;
    logic                      cmd_fire;
    logic                      data_fire;
    logic                      sts_fire;
    logic                      final_beat;
    logic                      sts_interr;
    logic                      unused_cmd_bits;

    assign cmd_btt   = bus.S_AXIS_CMD_TDATA[CMD_BTT_LSB +: BTT_WIDTH];
    assign cmd_saddr = bus.S_AXIS_CMD_TDATA[CMD_SADDR_LSB +: C_ADDR_WIDTH];
    assign cmd_tag   = bus.S_AXIS_CMD_TDATA[CMD_TAG_LSB +: TAG_WIDTH];
    assign cmd_eof   = bus.S_AXIS_CMD_TDATA[CMD_EOF_BIT];

    // TYPE/DSA/DRR are don't-care: every transfer is INCR.
    assign unused_cmd_bits = ^{bus.S_AXIS_CMD_TDATA[CMD_TYPE_BIT],
                               bus.S_AXIS_CMD_TDATA[CMD_DSA_LSB +: CMD_DSA_WIDTH],
                               bus.S_AXIS_CMD_TDATA[CMD_DRR_BIT],
                               bus.S_AXIS_CMD_TDATA[CMD_RSVD_LSB +: CMD_RSVD_WIDTH],
                               cmd_saddr[1:0], btt_round[BTT_WIDTH]};

    // A count of 2^21 wraps to 0; the down-counter still runs exactly 2^21 beats.
    assign btt_round  = {1'b0, cmd_btt} + (BTT_WIDTH+1)'(BEAT_BYTES - 1);
    assign final_beat = (beats_q == BEAT_CNT_WIDTH'(1));
    assign cmd_fire   = (state_q == ST_IDLE) && !rst && bus.S_AXIS_CMD_TVALID;
    assign data_fire  = (state_q == ST_DATA) && bus.M_AXIS_DATA_TREADY;
    assign sts_fire   = (state_q == ST_STATUS) && bus.M_AXIS_STS_TREADY;

`ifdef DATAMOVER_RESP_ERR_CHECK_EN
    logic interr_q, interr_d;

    assign cmd_err    = (cmd_btt == '0) || (cmd_saddr[1:0] != 2'b00);
    assign interr_d   = cmd_fire ? cmd_err : interr_q;
    assign sts_interr = interr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            interr_q <= 1'b0;
        end else begin
            interr_q <= interr_d;
        end
    end
`else
    assign cmd_err    = 1'b0;
    assign sts_interr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            eof_q   <= eof_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        eof_d   = eof_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    addr_d  = {cmd_saddr[C_ADDR_WIDTH-1:2], 2'b00};
                    beats_d = btt_round[BTT_WIDTH-1:2];
                    rem_d   = cmd_btt[1:0];
                    tag_d   = cmd_tag;
                    eof_d   = cmd_eof;
                    state_d = (cmd_err || cmd_btt == '0) ? ST_STATUS : ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (data_fire) begin
                    addr_d  = addr_q + C_ADDR_WIDTH'(BEAT_BYTES);
                    beats_d = beats_q - BEAT_CNT_WIDTH'(1);
                    state_d = final_beat ? ST_STATUS : ST_READ;
                end
            end
            ST_STATUS: begin
                if (sts_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.S_AXIS_CMD_TREADY  = 1'b0;
        bus.mem_rd_en          = 1'b0;
        bus.mem_rd_addr        = '0;
        bus.M_AXIS_DATA_TVALID = 1'b0;
        bus.M_AXIS_DATA_TDATA  = '0;
        bus.M_AXIS_DATA_TKEEP  = '0;
        bus.M_AXIS_DATA_TLAST  = 1'b0;
        bus.M_AXIS_STS_TVALID  = 1'b0;
        bus.M_AXIS_STS_TDATA   = '0;
        unique case (state_q)
            ST_IDLE: begin
                bus.S_AXIS_CMD_TREADY = !rst;
            end
            ST_READ: begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = addr_q;
            end
            ST_DATA: begin
                // Read data is held by the memory until the next strobe, so the beat stays stable.
                bus.M_AXIS_DATA_TVALID = 1'b1;
                bus.M_AXIS_DATA_TDATA  = bus.mem_rd_data;
                bus.M_AXIS_DATA_TKEEP  = final_beat ? final_keep(rem_q) : '1;
                bus.M_AXIS_DATA_TLAST  = final_beat && eof_q;
            end
            ST_STATUS: begin
                bus.M_AXIS_STS_TVALID = 1'b1;
                bus.M_AXIS_STS_TDATA  = sts_word(!sts_interr, sts_interr, tag_q);
            end
            default: begin
                bus.S_AXIS_CMD_TREADY = 1'b0;
            end
        endcase
    end

endmodule
